xor_decipher: RTL and testbench
===============================

Name: xor_decipher

Overview:
- Bit-serial XOR decipher. Inverse of the team's bit-serial XOR cipher block.
- Takes an N-bit ciphertext and an 8-bit key, and recovers the plaintext one bit per clock: pt[i] = ct[i] ^ key[i mod 8], LSB first.
- Uses the same level-based start/done handshake as the cipher, so the two blocks can be chained back-to-back for round-trip checking.
- Sits on the receive side of the XOR link.

Parameters:
- N, 16, ciphertext/plaintext width in bits; any N >= 1, not required to be a multiple of 8.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level request; sampled in IDLE and DONE only
- key  input  8  decipher key; captured in LOAD
- ciphertext  input  N  data to decipher; captured in LOAD
- done  output  1  high while in DONE (Moore, decoded from state)
- busy  output  1  high while in LOAD or PROCESS (Moore)
- plaintext  output  N  registered result
- blk_cnt  output  8  count of completed blocks; wraps 255->0

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; done=0; busy=0; plaintext=0; blk_cnt=0.
  - Internal key/ct/work registers and bit counter are cleared.
- Bit counter width is $clog2(N)+1.
- Key index is (counter mod 8), so the key repeats every 8 bits.
- FSM states:
  - IDLE: if start=1 -> LOAD; otherwise stay.
  - LOAD: capture key and ciphertext; clear work register and counter; -> PROCESS unconditionally.
  - PROCESS: each cycle sets work[cnt] = ct_reg[cnt] ^ key_reg[cnt mod 8], then cnt = cnt+1. When cnt == N-1 this cycle -> DONE.
  - DONE: if start=0 -> IDLE; otherwise stay.
- On the PROCESS->DONE transition edge:
  - plaintext is loaded with the final work value, including bit N-1 computed on that same edge.
  - blk_cnt increments.
- plaintext never shows partial results; it holds the previous block's value from LOAD through the end of PROCESS.
- Latency:
  - Let edge E0 be the edge at which start is sampled high in IDLE. LOAD executes at E0+1; PROCESS edges are E0+2 .. E0+N+1.
  - done and plaintext are valid after edge E0+N+1, i.e. N+2 cycles after start is sampled.
- Handshake:
  - The requester holds start high until it sees done.
  - The block stays in DONE while start=1. Dropping start returns the block to IDLE on the next edge.
  - A new block needs start=0 for at least one IDLE-observed edge, then start=1 again.
- start changes during LOAD/PROCESS are ignored; an operation cannot be aborted except by rst.
- key/ciphertext changes after LOAD have no effect on the block in flight.
- N=1: exactly one PROCESS cycle, with cnt==0==N-1 on the first cycle.
- rst mid-operation: immediate return to IDLE with all outputs at reset values; any partial work is lost.
- Illegal state encoding -> IDLE.

Test Plan:
- N=16, key=8'hA5, ciphertext=16'h5AA5, start held high -> done rises N+2=18 cycles after start is sampled, with plaintext=16'hFF00, busy=0, blk_cnt=1.
- Round trip: cipher with key=8'h0F, plaintext 16'h1234 -> 16'h1D3B; feed 16'h1D3B into xor_decipher -> plaintext=16'h1234.
- Hold start high for 10 cycles after done -> done and plaintext stay stable. Drop start -> IDLE next edge. Second block key=8'h3C, ct=16'h0000 -> plaintext=16'h3C3C, blk_cnt=2; plaintext holds 16'h1234 until the new DONE.
- Instance with N=12, key=8'h01, ct=12'h000 -> plaintext=12'h101, confirming the key wraps at bit 8.
- Assert rst after the 5th PROCESS cycle -> done=0, busy=0, plaintext=0, blk_cnt=0 immediately. A fresh block with key=8'hA5, ct=16'h5AA5 then gives 16'hFF00.
- Toggle ciphertext and key, and pulse start low then high, during PROCESS -> result reflects only the values captured in LOAD. Run 256 blocks -> blk_cnt wraps to 0.

Source files
------------

// File: rtl/xor_decipher_if.sv
// Request/response bundle between a requester and the bit-serial XOR decipher.
// The requester holds start until done; results are registered in the block.
interface xor_decipher_if #(
   parameter int unsigned N = 16
);
   logic         start;
   logic [7:0]   key;
   logic [N-1:0] ciphertext;
   logic         done;
   logic         busy;
   logic [N-1:0] plaintext;
   logic [7:0]   blk_cnt;

   modport master (
      output start, key, ciphertext,
      input  done, busy, plaintext, blk_cnt
   );

   modport slave (
      input  start, key, ciphertext,
      output done, busy, plaintext, blk_cnt
   );
endinterface

// File: rtl/xor_decipher.sv
// Bit-serial XOR decipher: pt[i] = ct[i] ^ key[i mod 8], one bit per clock, LSB first.
// Level start/done handshake matches the companion cipher so the two can be chained.
module xor_decipher #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           rst,
   xor_decipher_if.slave  bus
);
   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned KR = (N + 7) / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PROC = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e         state_q, state_d;
   logic [7:0]     key_q, key_d;
   logic [N-1:0]   ct_q, ct_d;
   logic [N-1:0]   work_q, work_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   pt_q, pt_d;
   logic [7:0]     blk_q, blk_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic [N-1:0]   key_rep_c;
   logic [N-1:0]   bit_mask_c;

   // Key replicated across the word so bit i lines up with key[i mod 8].
   always_comb begin
      key_rep_c  = N'({KR{key_q}});
      bit_mask_c = N'(1) << cnt_q;
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      ct_d    = ct_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      pt_d    = pt_q;
      blk_d   = blk_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            key_d   = bus.key;
            ct_d    = bus.ciphertext;
            work_d  = '0;
            cnt_d   = '0;
            state_d = S_PROC;
         end
         S_PROC: begin
            // work was cleared in LOAD, so OR-ing in one bit per cycle is exact
            work_d = work_q | (bit_mask_c & (ct_q ^ key_rep_c));
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = S_DONE;
               pt_d    = work_d;
               blk_d   = blk_q + 8'd1;
            end
         end
         S_DONE: begin
            if (!bus.start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_LOAD) || (state_d == S_PROC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         key_q   <= '0;
         ct_q    <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         pt_q    <= '0;
         blk_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         ct_q    <= ct_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         pt_q    <= pt_d;
         blk_q   <= blk_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.plaintext = pt_q;
   assign bus.blk_cnt   = blk_q;
endmodule

// File: tb/tb_xor_decipher.sv
// Directed bench for xor_decipher: N=16 and N=12 instances, scoreboard of expected plaintexts.
module tb_xor_decipher;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0]  blk_exp = 8'd0;
   logic [15:0] sb[$];

   always #5 clk = ~clk;

   xor_decipher_if #(.N(16)) if16 ();
   xor_decipher_if #(.N(12)) if12 ();

   xor_decipher #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
   xor_decipher #(.N(12)) u_dut12 (.clk(clk), .rst(rst), .bus(if12));

   function automatic logic [15:0] xmodel(input logic [15:0] d, input logic [7:0] k, input int n);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = d[i] ^ k[i % 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one block on the N=16 instance and leave start high at DONE.
   task automatic run_block(input logic [7:0] k, input logic [15:0] c, input bit perturb);
      logic [15:0] prev;
      logic [15:0] exp;
      int cyc;
      prev = if16.plaintext;
      sb.push_back(xmodel(c, k, 16));
      if16.key = k;
      if16.ciphertext = c;
      if16.start = 1'b1;
      cyc = 0;
      while (!if16.done && cyc < 100) begin
         tick();
         cyc++;
         if (!if16.done) begin
            check("pt_hold", 32'(if16.plaintext), 32'(prev));
            check("busy_run", 32'(if16.busy), 32'd1);
         end
         if (perturb && cyc == 5) begin
            if16.key = ~k;
            if16.ciphertext = 16'($urandom);
            if16.start = 1'b0;
         end
         if (perturb && cyc == 7) if16.start = 1'b1;
      end
      check("latency", 32'(cyc), 32'd18);
      exp = sb.pop_front();
      check("plaintext", 32'(if16.plaintext), 32'(exp));
      check("busy_done", 32'(if16.busy), 32'd0);
      blk_exp = blk_exp + 8'd1;
      check("blk_cnt", 32'(if16.blk_cnt), 32'(blk_exp));
   endtask

   task automatic gap();
      if16.start = 1'b0;
      tick();
      check("idle_done", 32'(if16.done), 32'd0);
      check("idle_busy", 32'(if16.busy), 32'd0);
   endtask

   initial begin
      int cyc;
      int nblk;
      logic [15:0] exp;
      logic [7:0]  rk;
      logic [15:0] rc;
      if16.start = 1'b0; if16.key = '0; if16.ciphertext = '0;
      if12.start = 1'b0; if12.key = '0; if12.ciphertext = '0;
      tick();
      tick();
      check("rst_done", 32'(if16.done), 32'd0);
      check("rst_busy", 32'(if16.busy), 32'd0);
      check("rst_pt", 32'(if16.plaintext), 32'd0);
      check("rst_blk", 32'(if16.blk_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // basic block
      run_block(8'hA5, 16'h5AA5, 1'b0);
      check("basic_const", 32'(if16.plaintext), 32'h0000FF00);
      gap();

      // round trip through the cipher model
      run_block(8'h0F, xmodel(16'h1234, 8'h0F, 16), 1'b0);
      check("roundtrip", 32'(if16.plaintext), 32'h00001234);

      // hold start in DONE
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_done", 32'(if16.done), 32'd1);
         check("hold_pt", 32'(if16.plaintext), 32'h00001234);
      end
      gap();
      run_block(8'h3C, 16'h0000, 1'b0);
      check("second_const", 32'(if16.plaintext), 32'h00003C3C);
      gap();

      // N=12 instance: key wraps at bit 8
      sb.push_back(xmodel(16'h0000, 8'h01, 12));
      if12.key = 8'h01;
      if12.ciphertext = 12'h000;
      if12.start = 1'b1;
      cyc = 0;
      while (!if12.done && cyc < 100) begin
         tick();
         cyc++;
      end
      check("n12_latency", 32'(cyc), 32'd14);
      exp = sb.pop_front();
      check("n12_pt", 32'(if12.plaintext), 32'(exp));
      check("n12_const", 32'(if12.plaintext), 32'h00000101);
      check("n12_blk", 32'(if12.blk_cnt), 32'd1);
      if12.start = 1'b0;

      // reset after the 5th PROCESS edge
      if16.key = 8'h77;
      if16.ciphertext = 16'hBEEF;
      if16.start = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("pre_rst_busy", 32'(if16.busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_done", 32'(if16.done), 32'd0);
      check("mid_rst_busy", 32'(if16.busy), 32'd0);
      check("mid_rst_pt", 32'(if16.plaintext), 32'd0);
      check("mid_rst_blk", 32'(if16.blk_cnt), 32'd0);
      if16.start = 1'b0;
      blk_exp = 8'd0;
      tick();
      rst = 1'b0;
      tick();
      run_block(8'hA5, 16'h5AA5, 1'b0);
      check("post_rst_const", 32'(if16.plaintext), 32'h0000FF00);
      gap();

      // input changes during PROCESS are ignored
      run_block(8'h5A, 16'hC3C3, 1'b1);
      check("perturb_const", 32'(if16.plaintext), 32'h00009999);
      gap();

      // run until blk_cnt wraps
      nblk = 256 - int'(blk_exp);
      for (int b = 0; b < nblk; b++) begin
         rk = 8'($urandom);
         rc = 16'($urandom);
         run_block(rk, rc, 1'b0);
         gap();
      end
      check("blk_wrap", 32'(if16.blk_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
